// File: rtl/awg_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// awg_sweep_ctrl_if
// Groups the sweep controller's request/config inputs and its registered
// generator controls and status pulses.
//
// Request semantics (no valid/ready pair on this block):
//   start and stop are single-cycle requests sampled on the rising clock
//   edge. There is no ready signal. start is acted on only while the
//   controller is idle, which is when busy is low and state_dbg is IDLE.
//   An accepted start raises busy on the next cycle. A rejected start
//   (f_start > f_stop) gives a one-cycle err pulse instead. stop is honoured
//   in every state and takes priority over start.
//
// Modports:
//   master : drives start/stop/config and observes outputs (bench or host)
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface awg_sweep_ctrl_if #(
  parameter int DWELL_W = 16
);
  // requests and sweep configuration
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic [11:0]        f_start;
  logic [11:0]        f_stop;
  logic [11:0]        f_step;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         amp_in;
  logic [7:0]         phase_in;

  // registered generator controls and status
  logic               en;
  logic [11:0]        freq;
  logic [2:0]         amp;
  logic [7:0]         phase;
  logic               busy;
  logic               done;
  logic               err;
  logic               step_stb;
  logic [1:0]         state_dbg;

  modport master (
    output start, stop, mode, f_start, f_stop, f_step, dwell, amp_in, phase_in,
    input  en, freq, amp, phase, busy, done, err, step_stb, state_dbg
  );

  modport slave (
    input  start, stop, mode, f_start, f_stop, f_step, dwell, amp_in, phase_in,
    output en, freq, amp, phase, busy, done, err, step_stb, state_dbg
  );
endinterface

// File: rtl/awg_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// awg_sweep_ctrl
// Frequency-sweep sequencer for a triangle-wave generator. It steps freq from
// f_start towards f_stop by f_step. Each value is held for max(dwell,1)
// clocks. At the top of a leg the controller either finishes (single), jumps
// back to f_start (repeat) or turns round (bounce).
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : awg_sweep_ctrl_if.slave
//                inputs  start, stop, mode, f_start, f_stop, f_step, dwell,
//                        amp_in, phase_in
//                outputs en, freq, amp, phase, busy, done, err, step_stb,
//                        state_dbg (current FSM state, IDLE=0 RUN=1 DONE=2)
// ---------------------------------------------------------------------------
module awg_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  awg_sweep_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] DW_ONE = DWELL_W'(1);

  state_t             state;
  logic               dir_down;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_lim;   // max(dwell,1)-1, the count at which freq advances
  logic [1:0]         mode_q;
  logic [11:0]        fs_q;
  logic [11:0]        fe_q;
  logic [11:0]        fst_q;

  logic               en_q;
  logic [11:0]        freq_q;
  logic [2:0]         amp_q;
  logic [7:0]         phase_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               stb_q;

  // Saturating add: the 13-bit sum cannot wrap, so it is clipped at hi.
  function automatic logic [11:0] add_clip(input logic [11:0] a, input logic [11:0] b,
                                           input logic [11:0] hi);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, hi}) ? hi : s[11:0];
  endfunction

  // Saturating subtract: a negative signed 13-bit difference clips to lo.
  function automatic logic [11:0] sub_clip(input logic [11:0] a, input logic [11:0] b,
                                           input logic [11:0] lo);
    logic signed [12:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < $signed({1'b0, lo})) ? lo : d[11:0];
  endfunction

  // Next frequency and direction if this cycle is an advance.
  // While running, freq always stays between fs_q and fe_q. So "not below the
  // top" means "at the top" and "not above the bottom" means "at the bottom".
  logic [11:0] adv_freq;
  logic        adv_down;
  logic        adv_end;

  always_comb begin
    adv_freq = freq_q;
    adv_down = dir_down;
    adv_end  = 1'b0;
    if (!dir_down) begin
      if (freq_q < fe_q) begin
        adv_freq = add_clip(freq_q, fst_q, fe_q);
      end else begin
        case (mode_q)
          2'b01:   adv_freq = fs_q;
          2'b10: begin
            adv_down = 1'b1;
            adv_freq = sub_clip(fe_q, fst_q, fs_q);
          end
          default: adv_end = 1'b1;   // 00 and 11 both end the sweep
        endcase
      end
    end else begin
      if (freq_q > fs_q) begin
        adv_freq = sub_clip(freq_q, fst_q, fs_q);
      end else begin
        adv_down = 1'b0;
        adv_freq = add_clip(fs_q, fst_q, fe_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dir_down  <= 1'b0;
      cnt       <= '0;
      dwell_lim <= '0;
      mode_q    <= '0;
      fs_q      <= '0;
      fe_q      <= '0;
      fst_q     <= '0;
      en_q      <= 1'b0;
      freq_q    <= '0;
      amp_q     <= 3'd1;
      phase_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      stb_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          en_q   <= 1'b0;
          freq_q <= '0;
          busy_q <= 1'b0;
          // When start and stop arrive together, stop wins and nothing happens.
          if (bus.start && !bus.stop) begin
            if (bus.f_start <= bus.f_stop) begin
              mode_q    <= bus.mode;
              fs_q      <= bus.f_start;
              fe_q      <= bus.f_stop;
              fst_q     <= bus.f_step;
              dwell_lim <= (bus.dwell == '0) ? '0 : bus.dwell - DW_ONE;
              amp_q     <= (bus.amp_in == 3'd0) ? 3'd1 : bus.amp_in;
              phase_q   <= bus.phase_in;
              state     <= S_RUN;
              en_q      <= 1'b1;
              busy_q    <= 1'b1;
              freq_q    <= bus.f_start;
              dir_down  <= 1'b0;
              cnt       <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (bus.stop) begin
            state    <= S_IDLE;
            en_q     <= 1'b0;
            freq_q   <= '0;
            busy_q   <= 1'b0;
            dir_down <= 1'b0;
            cnt      <= '0;
          end else if (fst_q != '0) begin
            // A zero step is tone mode: freq is simply held until stop.
            if (cnt == dwell_lim) begin
              cnt <= '0;
              if (adv_end) begin
                state    <= S_DONE;
                done_q   <= 1'b1;
                en_q     <= 1'b0;
                busy_q   <= 1'b0;
                freq_q   <= '0;
                dir_down <= 1'b0;
              end else begin
                freq_q   <= adv_freq;
                dir_down <= adv_down;
                stb_q    <= (adv_freq != freq_q);
              end
            end else begin
              cnt <= cnt + DW_ONE;
            end
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          en_q   <= 1'b0;
          busy_q <= 1'b0;
          freq_q <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.en        = en_q;
  assign bus.freq      = freq_q;
  assign bus.amp       = amp_q;
  assign bus.phase     = phase_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.step_stb  = stb_q;
  assign bus.state_dbg = state;

endmodule
